// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, threshold/sticky error flags, flush and optional FWFT read.
// Read latency 1 cycle (FWFT=0) or 0 (FWFT=1); writes when full and reads when empty are dropped and flagged.
module sync_fifo_ext #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 16,
  parameter int PTR_WIDTH  = $clog2(MEM_DEPTH),
  parameter bit FWFT       = 1'b0,
  parameter int AF_THRESH  = MEM_DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [PTR_WIDTH:0]    o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [PTR_WIDTH:0]    w_ptr;
  logic [PTR_WIDTH:0]    r_ptr;
  logic [PTR_WIDTH:0]    count;
  logic [PTR_WIDTH-1:0]  w_idx;
  logic [PTR_WIDTH-1:0]  r_idx;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;

  // Extra MSB on each pointer separates full from empty when low bits match.
  assign count = w_ptr - r_ptr;
  assign w_idx = w_ptr[PTR_WIDTH-1:0];
  assign r_idx = r_ptr[PTR_WIDTH-1:0];
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  assign wr_acc = i_wr_en && !full  && !i_flush;
  assign rd_acc = i_rd_en && !empty && !i_flush;

  assign o_full         = full;
  assign o_empty        = empty;
  assign o_count        = count;
  assign o_almost_full  = (count >= AF_C);
  assign o_almost_empty = (count <= AE_C);

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[w_idx] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else if (i_flush) begin
      w_ptr       <= '0;
      r_ptr       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + 1'b1;
      if (rd_acc) r_ptr <= r_ptr + 1'b1;
      if (i_wr_en && full)  o_overflow  <= 1'b1;
      if (i_rd_en && empty) o_underflow <= 1'b1;
    end
  end

  if (FWFT) begin : g_fwft
    assign o_rd_data  = empty ? '0 : mem[r_idx];
    assign o_rd_valid = !empty;
  end else begin : g_reg
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (i_flush) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[r_idx];
      end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Directed bench for sync_fifo_ext: one registered-read instance and one FWFT instance.
module tb_sync_fifo_ext;

  logic        i_clk;
  logic        i_rstn;

  logic        flush, wr_en, rd_en;
  logic [31:0] wr_data, rd_data;
  logic        rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0]  count;

  logic        f_flush, f_wr_en, f_rd_en;
  logic [31:0] f_wr_data, f_rd_data;
  logic        f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0]  f_count;

  int n_chk  = 0;
  int n_pass = 0;

  sync_fifo_ext #(.FWFT(1'b0)) u_reg (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(flush), .i_wr_data(wr_data),
    .i_wr_en(wr_en), .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .o_full(full), .o_empty(empty), .o_almost_full(almost_full),
    .o_almost_empty(almost_empty), .o_count(count), .o_overflow(overflow),
    .o_underflow(underflow)
  );

  sync_fifo_ext #(.FWFT(1'b1)) u_fwft (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(f_flush), .i_wr_data(f_wr_data),
    .i_wr_en(f_wr_en), .i_rd_en(f_rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_rd_valid),
    .o_full(f_full), .o_empty(f_empty), .o_almost_full(f_almost_full),
    .o_almost_empty(f_almost_empty), .o_count(f_count), .o_overflow(f_overflow),
    .o_underflow(f_underflow)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rstn = 1'b0;
    flush = 0; wr_en = 0; rd_en = 0; wr_data = 0;
    f_flush = 0; f_wr_en = 0; f_rd_en = 0; f_wr_data = 0;
    #2;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_aempty", 32'(almost_empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", rd_data, 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    chk("rst_f_valid", 32'(f_rd_valid), 32'd0);
    chk("rst_f_data", f_rd_data, 32'd0);
    #10 i_rstn = 1'b1;

    // FWFT: word written into an empty FIFO shows up without a read request.
    f_wr_en = 1; f_wr_data = 32'hA5;
    cyc();
    chk("fwft_valid", 32'(f_rd_valid), 32'd1);
    chk("fwft_data", f_rd_data, 32'hA5);
    f_wr_data = 32'h5A;
    cyc();
    f_wr_en = 0;
    chk("fwft_cnt2", 32'(f_count), 32'd2);
    chk("fwft_head", f_rd_data, 32'hA5);
    f_rd_en = 1;
    cyc();
    chk("fwft_pop1", f_rd_data, 32'h5A);
    cyc();
    chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    chk("fwft_pop_data0", f_rd_data, 32'd0);
    chk("fwft_pop_valid0", 32'(f_rd_valid), 32'd0);
    cyc();
    f_rd_en = 0;
    chk("fwft_udf", 32'(f_underflow), 32'd1);

    // Fill, almost-full threshold, overflow.
    chk("fill_ae0", 32'(almost_empty), 32'd1);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1; wr_data = 32'(i);
      cyc();
      chk("fill_cnt", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'(i + 1 >= 14));
    end
    chk("fill_full", 32'(full), 32'd1);
    wr_data = 32'hFF;
    cyc();
    wr_en = 0;
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_cnt", 32'(count), 32'd16);

    // Drain with one-cycle read latency, almost-empty threshold, underflow.
    for (int i = 0; i < 16; i++) begin
      rd_en = 1;
      cyc();
      chk("drain_valid", 32'(rd_valid), 32'd1);
      chk("drain_data", rd_data, 32'(i));
      chk("drain_cnt", 32'(count), 32'(15 - i));
      chk("drain_ae", 32'(almost_empty), 32'(15 - i <= 2));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    cyc();
    rd_en = 0;
    chk("udf_flag", 32'(underflow), 32'd1);
    chk("udf_valid", 32'(rd_valid), 32'd0);
    chk("udf_hold", rd_data, 32'h0F);

    // Flush at count 5 with both error flags set; concurrent write is dropped.
    for (int i = 0; i < 5; i++) begin
      wr_en = 1; wr_data = 32'h50 + 32'(i);
      cyc();
    end
    chk("pre_flush_cnt", 32'(count), 32'd5);
    chk("pre_flush_ovf", 32'(overflow), 32'd1);
    flush = 1; wr_data = 32'hDD;
    cyc();
    flush = 0; wr_en = 0;
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_udf", 32'(underflow), 32'd0);
    chk("flush_data", rd_data, 32'd0);
    chk("flush_valid", 32'(rd_valid), 32'd0);

    // Hold 8 entries and stream read+write across the pointer wrap.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1; wr_data = 32'h100 + 32'(i);
      cyc();
    end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1; rd_en = 1; wr_data = 32'h108 + 32'(k);
      cyc();
      chk("wrap_data", rd_data, 32'h100 + 32'(k));
      chk("wrap_cnt", 32'(count), 32'd8);
    end
    rd_en = 0;

    // Full with simultaneous read and write.
    for (int i = 0; i < 8; i++) begin
      wr_data = 32'h130 + 32'(i);
      cyc();
    end
    chk("full2", 32'(full), 32'd1);
    rd_en = 1; wr_data = 32'hBEEF;
    cyc();
    rd_en = 0; wr_en = 0;
    chk("rw_full_cnt", 32'(count), 32'd15);
    chk("rw_full_ovf", 32'(overflow), 32'd1);
    chk("rw_full_data", rd_data, 32'h128);

    // Asynchronous reset in the middle of a write.
    wr_en = 1; wr_data = 32'hEE;
    @(posedge i_clk);
    #3 i_rstn = 1'b0;
    #1;
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_ovf", 32'(overflow), 32'd0);
    chk("arst_data", rd_data, 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    wr_en = 0;
    #3 i_rstn = 1'b1;
    wr_en = 1; wr_data = 32'h77;
    f_wr_en = 1; f_wr_data = 32'h88;
    cyc();
    wr_en = 0; f_wr_en = 0;
    chk("post_rst_cnt", 32'(count), 32'd1);
    chk("post_rst_fwft", f_rd_data, 32'h88);
    rd_en = 1;
    cyc();
    rd_en = 0;
    chk("post_rst_data", rd_data, 32'h77);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
